// File: rtl/tt_um_urish_dffram_seq.sv
// tt_um_urish_dffram_seq: strobed-command byte RAM with auto-incrementing pointer and FILL engine
module tt_um_urish_dffram_seq #(
  parameter int WORDS = 32,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int DEPTH = WORDS * BYTES_PER_WORD;
  localparam int PW = $clog2(DEPTH);
  localparam int LB = $clog2(BYTES_PER_WORD);
  localparam int WB = 8 * BYTES_PER_WORD;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state;
  logic s1, s2, s3;
  logic [PW-1:0] ptr;
  logic [PW-1:0] lane;
  logic [3:0] count;
  logic [7:0] fill_data;
  logic [7:0] rbyte;
  logic [7:0] wdata;
  logic err, wrap;
  logic [WB-1:0] mem [WORDS];
  logic [WB-1:0] word;
  logic [2:0] op;
  logic cmd, we, adv, unused;
  assign op = ui_in[6:4];
  assign cmd = s2 & ~s3 & (state == IDLE);
  assign we = rst_n & ((state == FILL) | (cmd & (op == 3'd2)));
  assign adv = (state == FILL) | (cmd & ((op == 3'd2) | (op == 3'd3)));
  assign wdata = (state == FILL) ? fill_data : uio_in;
  assign lane = ptr & PW'(BYTES_PER_WORD - 1);
  assign word = mem[ptr[PW-1:LB]];
  assign rbyte = 8'(word >> {lane, 3'b000});
  assign uio_out = '0;
  assign uio_oe = '0;
  assign unused = ena;
  always_ff @(posedge clk)
    if (we)
      for (int l = 0; l < BYTES_PER_WORD; l++)
        if (lane == PW'(l)) mem[ptr[PW-1:LB]][8*l +: 8] <= wdata;
  always_ff @(posedge clk)
    if (!rst_n) begin
      {s1, s2, s3} <= '0;
      state <= IDLE;
      ptr <= '0;
      count <= '0;
      fill_data <= '0;
      err <= 1'b0;
      wrap <= 1'b0;
      uo_out <= '0;
    end else begin
      s1 <= ui_in[7];
      s2 <= s1;
      s3 <= s2;
      if (adv) begin
        ptr <= ptr + 1'b1;
        if (&ptr) wrap <= 1'b1;
      end
      if (state == FILL) begin
        // a strobe edge arriving while busy is lost, so flag it
        if (s2 & ~s3) err <= 1'b1;
        if (count == '0) state <= IDLE;
        else count <= count - 1'b1;
      end else if (cmd) begin
        case (op)
          3'd1: ptr <= uio_in[PW-1:0];
          3'd3, 3'd4: uo_out <= rbyte;
          3'd5: begin
            fill_data <= uio_in;
            count <= ui_in[3:0];
            state <= FILL;
          end
          3'd6: uo_out <= {err, wrap, 6'b0};
          3'd7: begin
            err <= 1'b0;
            wrap <= 1'b0;
          end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_tt_um_urish_dffram_seq.sv
// tb_tt_um_urish_dffram_seq: three geometries driven in lockstep against a byte-array reference model
module tb_tt_um_urish_dffram_seq;
  localparam logic [2:0] NOP = 0, SET = 1, WR = 2, RD = 3, PEEK = 4, FILLC = 5, STAT = 6, CLR = 7;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo [3];
  logic [7:0] uout [3];
  logic [7:0] uoe [3];
  int n_cmp = 0;
  int n_fail = 0;
  int dep [3] = '{128, 64, 32};
  logic [7:0] m_mem [3][256];
  int m_ptr [3];
  logic [7:0] m_uo [3];
  logic m_err [3];
  logic m_wrap [3];

  always #5 clk = ~clk;

  tt_um_urish_dffram_seq #(.WORDS(32), .BYTES_PER_WORD(4)) u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo[0]), .uio_out(uout[0]), .uio_oe(uoe[0]));
  tt_um_urish_dffram_seq #(.WORDS(64), .BYTES_PER_WORD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo[1]), .uio_out(uout[1]), .uio_oe(uoe[1]));
  tt_um_urish_dffram_seq #(.WORDS(16), .BYTES_PER_WORD(2)) u2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo[2]), .uio_out(uout[2]), .uio_oe(uoe[2]));

  task automatic m_adv(input int i);
    m_ptr[i] = (m_ptr[i] + 1) % dep[i];
    if (m_ptr[i] == 0) m_wrap[i] = 1'b1;
  endtask

  task automatic m_put(input int i, input logic [7:0] d);
    m_mem[i][m_ptr[i]] = d;
    m_adv(i);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_ptr[i] = 0;
      m_uo[i] = 8'h00;
      m_err[i] = 1'b0;
      m_wrap[i] = 1'b0;
    end
  endtask

  task automatic m_exec(input logic [2:0] op, input logic [3:0] arg, input logic [7:0] d);
    for (int i = 0; i < 3; i++)
      case (op)
        SET: m_ptr[i] = d % dep[i];
        WR: m_put(i, d);
        RD: begin
          m_uo[i] = m_mem[i][m_ptr[i]];
          m_adv(i);
        end
        PEEK: m_uo[i] = m_mem[i][m_ptr[i]];
        FILLC: for (int j = 0; j <= int'(arg); j++) m_put(i, d);
        STAT: m_uo[i] = {m_err[i], m_wrap[i], 6'b0};
        CLR: begin
          m_err[i] = 1'b0;
          m_wrap[i] = 1'b0;
        end
        default: ;
      endcase
  endtask

  // raise STB with operands, hold through the execute edge, then two low cycles
  task automatic issue(input logic [2:0] op, input logic [3:0] arg, input logic [7:0] d);
    @(negedge clk);
    ui_in = {1'b1, op, arg};
    uio_in = d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ui_in = 8'h00;
    repeat (2) @(posedge clk);
  endtask

  task automatic cmd(input logic [2:0] op, input logic [3:0] arg, input logic [7:0] d);
    issue(op, arg, d);
    m_exec(op, arg, d);
    if (op == FILLC && arg > 4'd3) repeat (int'(arg) - 3) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ui_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp += 3;
      if (uo[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_uo inst%0d: got %h want 00", i, uo[i]);
      end
      if (uout[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL uio_out inst%0d: got %h want 00", i, uout[i]);
      end
      if (uoe[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL uio_oe inst%0d: got %h want 00", i, uoe[i]);
      end
    end
    cmd(STAT, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (uo[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_status inst%0d: got %h want 00", i, uo[i]);
      end
    end
  endtask

  task automatic init_mem();
    for (int a = 0; a < 256; a++) cmd(WR, 0, 8'($urandom));
    cmd(CLR, 0, 0);
  endtask

  task automatic test_write_read();
    logic [7:0] pat [3] = '{8'hA1, 8'hB2, 8'hC3};
    cmd(SET, 0, 8'd5);
    for (int j = 0; j < 3; j++) cmd(WR, 0, pat[j]);
    cmd(SET, 0, 8'd5);
    for (int j = 0; j < 3; j++) begin
      cmd(RD, 0, 0);
      #1;
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (uo[i] !== pat[j]) begin
          n_fail++;
          $display("FAIL read_back%0d inst%0d: got %h want %h", j, i, uo[i], pat[j]);
        end
      end
    end
    cmd(PEEK, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (uo[i] !== m_mem[i][8]) begin
        n_fail++;
        $display("FAIL ptr_after_reads inst%0d: got %h want %h", i, uo[i], m_mem[i][8]);
      end
    end
    cmd(SET, 0, 8'd4);
    cmd(PEEK, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (uo[i] !== m_mem[i][4]) begin
        n_fail++;
        $display("FAIL lane0_untouched inst%0d: got %h want %h", i, uo[i], m_mem[i][4]);
      end
    end
  endtask

  task automatic test_wrap();
    cmd(SET, 0, 8'h7E);
    cmd(WR, 0, 8'h11);
    cmd(WR, 0, 8'h22);
    cmd(PEEK, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (uo[i] !== m_mem[i][0]) begin
        n_fail++;
        $display("FAIL wrap_ptr0 inst%0d: got %h want %h", i, uo[i], m_mem[i][0]);
      end
    end
    cmd(STAT, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (uo[i] !== 8'h40) begin
        n_fail++;
        $display("FAIL wrap_status inst%0d: got %h want 40", i, uo[i]);
      end
    end
    cmd(CLR, 0, 0);
    cmd(STAT, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (uo[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL clear_status inst%0d: got %h want 00", i, uo[i]);
      end
    end
    cmd(SET, 0, 8'h7F);
    cmd(PEEK, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (uo[i] !== 8'h22) begin
        n_fail++;
        $display("FAIL wrap_last_byte inst%0d: got %h want 22", i, uo[i]);
      end
    end
  endtask

  task automatic test_fill_timing();
    cmd(SET, 0, 8'd10);
    cmd(FILLC, 4'd3, 8'h5A);
    cmd(PEEK, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (uo[i] !== m_uo[i]) begin
        n_fail++;
        $display("FAIL fill_first_idle_peek inst%0d: got %h want %h", i, uo[i], m_uo[i]);
      end
    end
    cmd(SET, 0, 8'd10);
    for (int j = 0; j < 5; j++) begin
      cmd(RD, 0, 0);
      #1;
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (uo[i] !== m_uo[i]) begin
          n_fail++;
          $display("FAIL fill_byte%0d inst%0d: got %h want %h", j, i, uo[i], m_uo[i]);
        end
      end
    end
    cmd(STAT, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (uo[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL fill_no_err inst%0d: got %h want 00", i, uo[i]);
      end
    end
  endtask

  task automatic test_fill_drop();
    cmd(CLR, 0, 0);
    cmd(SET, 0, 8'h40);
    issue(FILLC, 4'd15, 8'h3C);
    m_exec(FILLC, 4'd15, 8'h3C);
    issue(WR, 0, 8'h99);
    for (int i = 0; i < 3; i++) m_err[i] = 1'b1;
    repeat (12) @(posedge clk);
    cmd(STAT, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (uo[i] !== 8'h80) begin
        n_fail++;
        $display("FAIL drop_status inst%0d: got %h want 80", i, uo[i]);
      end
    end
    cmd(SET, 0, 8'h50);
    cmd(PEEK, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (uo[i] !== m_uo[i]) begin
        n_fail++;
        $display("FAIL drop_no_write inst%0d: got %h want %h", i, uo[i], m_uo[i]);
      end
    end
    cmd(CLR, 0, 0);
  endtask

  task automatic test_reset_fill();
    logic [7:0] d;
    d = ~m_mem[0][8'h25];
    cmd(SET, 0, 8'h20);
    issue(FILLC, 4'd15, d);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 5; j++) m_put(i, d);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (uo[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL rst_fill_uo inst%0d: got %h want 00", i, uo[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    cmd(PEEK, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (uo[i] !== m_uo[i]) begin
        n_fail++;
        $display("FAIL rst_fill_ptr0 inst%0d: got %h want %h", i, uo[i], m_uo[i]);
      end
    end
    cmd(SET, 0, 8'h20);
    for (int j = 0; j < 6; j++) begin
      cmd(RD, 0, 0);
      #1;
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (uo[i] !== m_uo[i]) begin
          n_fail++;
          $display("FAIL rst_fill_byte%0d inst%0d: got %h want %h", j, i, uo[i], m_uo[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [3:0] arg;
    for (int n = 0; n < 150; n++) begin
      op = 3'($urandom_range(0, 7));
      arg = (op == FILLC) ? 4'($urandom_range(0, 15)) : 4'($urandom);
      cmd(op, arg, 8'($urandom));
      #1;
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (uo[i] !== m_uo[i]) begin
          n_fail++;
          $display("FAIL random%0d op%0d inst%0d: got %h want %h", n, op, i, uo[i], m_uo[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_write_read();
    test_wrap();
    test_fill_timing();
    test_fill_drop();
    test_reset_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/tt_um_urish_dffram_seq.md
# tt_um_urish_dffram_seq

Strobed-command byte RAM for a Tiny Tapeout tile: parametrised word-organised storage with per-byte write lanes, an auto-incrementing byte pointer, and a multi-cycle FILL engine. The host drives opcodes over the dedicated inputs and reads data and status on the dedicated outputs. It replaces single-cycle direct-address access with a synchronised, sequential command interface.

## Interface
- WORDS, 32, storage depth in words; power of two, 2..64
- BYTES_PER_WORD, 4, byte lanes per word; 1, 2 or 4; WORDS*BYTES_PER_WORD ≤ 256
- DEPTH (derived), WORDS*BYTES_PER_WORD, byte capacity; pointer width PW = clog2(DEPTH)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  tile enable; ignored
- ui_in  in  8  [7] STB command strobe; [6:4] opcode; [3:0] ARG
- uio_in  in  8  write data / address operand
- uo_out  out  8  read data or status, registered
- uio_out  out  8  constant 0
- uio_oe  out  8  constant 0 (all inputs)

## Operation
- Storage: WORDS × (8·BYTES_PER_WORD) flops, not reset. Byte at pointer P is lane P[LB-1:0] of word P[PW-1:LB], LB = clog2(BYTES_PER_WORD). Writes touch only that lane.
- STB passes through two synchroniser flops (s1, s2) plus a history flop s3. A command is accepted when s2 & ~s3 is true. opcode, ARG and uio_in are sampled on that same edge; the host holds them stable from STB rise until STB fall.
- Opcodes:
  - 000 NOP.
  - 001 SET_ADDR: ptr ← uio_in[PW-1:0].
  - 010 WRITE: mem[ptr] ← uio_in, then ptr++.
  - 011 READ: uo_out ← mem[ptr], then ptr++.
  - 100 PEEK: uo_out ← mem[ptr], ptr unchanged.
  - 101 FILL: capture uio_in and count ← ARG, then enter FILL. Each FILL cycle writes the captured byte at ptr, increments ptr and decrements count. Exit to IDLE after the write made with count == 0, so ARG+1 bytes are written in total.
  - 110 STATUS: uo_out ← {err, wrap, 6'b0}.
  - 111 CLEAR: err ← 0, wrap ← 0.
- FSM states:
  - IDLE: executes accepted commands.
  - FILL: any accepted STB edge is dropped, no command executes, and err ← 1 (sticky).
- Pointer arithmetic is modulo DEPTH. Any increment from DEPTH-1 to 0 sets wrap (sticky). SET_ADDR does not touch wrap.
- uo_out holds its value until the next READ, PEEK or STATUS.
- Reset values: uo_out 0, ptr 0, err 0, wrap 0, state IDLE, s1/s2/s3 0, count 0. Memory contents are undefined after reset.
- Reset during FILL aborts immediately; no write occurs on the reset edge.

## Timing
- Let k be the first clk edge that samples STB = 1.
  - Edge k: s1 ← 1.
  - Edge k+1: s2 ← 1; the command is detected in the cycle after k+1.
  - Edge k+2: the command executes and s3 ← 1.
- READ, PEEK and STATUS: new uo_out is visible after edge k+2.
- WRITE and SET_ADDR: memory and ptr are updated at edge k+2. A following PEEK sees the new byte.
- FILL:
  - Edge k+2: enters FILL and captures the data byte.
  - Edges k+3 through k+3+ARG: one write per edge.
  - The state returns to IDLE at edge k+3+ARG, and the next command is accepted from then on.
- Holding STB high issues exactly one command. The minimum STB low time before the next command is 2 cycles.

## Test plan
- Reset, then STATUS → uo_out = 8'h00. Check uio_out = 0 and uio_oe = 0.
- SET_ADDR 5; WRITE A1, B2, C3; SET_ADDR 5; READ ×3 → uo_out = A1, B2, C3 in turn. ptr = 8. Word 1 lanes 1–3 hold A1/B2/C3 and lane 0 is unchanged.
- SET_ADDR 0x7E (DEPTH 128); WRITE 11, 22 → second write lands at address 0x7F; ptr = 0; STATUS = 8'h40. CLEAR then STATUS = 8'h00.
- SET_ADDR 10; FILL ARG=3 data 5A → addresses 10–13 = 5A and address 14 is untouched. The state is back in IDLE exactly 4 cycles after the execute edge; PEEK shows mem[14].
- Issue a STB during FILL ARG=15 → that command is ignored; after FILL, STATUS = 8'h80.
- Assert rst_n low mid-FILL → writes stop that cycle, ptr = 0 and uo_out = 0. Repeat the WRITE/READ scenario at parameters WORDS=64, BYTES_PER_WORD=1 and WORDS=16, BYTES_PER_WORD=2.
